fsm29_resp_checker: RTL
=======================

# fsm29_resp_checker

Synthesizable response checker for the fsm29 lab. It sits at the DUT output, opposite the stimulus side, and holds a table of expected `y` values loaded before a run. After `start`, it compares the live `y` against one table entry per clock. It stops at an end-marker entry and reports pass/fail, an error count and the first failing index, so the FSM can be checked on the board without a simulator.

## Interface
- `DEPTH`, 256: number of table entries; `AW = $clog2(DEPTH)`.
- `CNT_W`, 16: width of the error counter.
- `clk`  in  1  rising-edge clock; shared with the DUT.
- `reset`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  write strobe for one table entry.
- `load_addr`  in  AW  table write address.
- `load_data`  in  2  table entry: bit1 = `last` (end marker), bit0 = `exp_y`.
- `start`  in  1  one-cycle pulse that begins a run.
- `y`  in  1  DUT output under check.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid only in DONE; equals `err_count == 0`.
- `err_count`  out  CNT_W  number of mismatches; saturates at all-ones.
- `first_err_idx`  out  AW  index of the first mismatch.
- `vec_idx`  out  AW  index of the entry currently being compared.

## Operation
- **Reset.** All outputs reset to 0. State goes to IDLE. Table contents are not reset.
- **IDLE.**
  - `load_en` writes `load_data` to `load_addr` on the clock edge.
  - `start` clears `err_count`, `first_err_idx`, `vec_idx` and an internal `seen_err` flag, then moves to RUN.
- **RUN.** Each cycle, with `e = table[vec_idx]`:
  - If `e.last`: go to DONE. No compare is made for this entry and `vec_idx` holds.
  - Otherwise, if `y != e.exp_y`:
    - `err_count` increments, saturating at all-ones.
    - If `seen_err` is clear, `first_err_idx <= vec_idx` and `seen_err` sets.
  - Otherwise, if `vec_idx == DEPTH-1`: that entry is compared, then go to DONE. This is the implicit end marker.
  - Otherwise, `vec_idx` increments.
- **DONE.**
  - Outputs hold.
  - `start` restarts exactly as from IDLE.
  - `load_en` writes are accepted.
- **Ignored inputs.**
  - `load_en` is ignored in RUN; the table is frozen during a run.
  - `start` is ignored in RUN.
- **Reset mid-run.** Reset aborts to IDLE immediately with all outputs 0. Table contents are retained.
- **Simultaneous `load_en` and `start` in IDLE/DONE.** The write lands. The run's first compare uses the updated entry when `load_addr == 0`.
- **Empty table.** If entry 0 has `last` set, the block goes RUN → DONE in one cycle with `pass = 1` and `err_count = 0`.

## Timing
- The table read is combinational. The compare uses `y` as sampled on the same rising edge that advances `vec_idx`.
- `start` is sampled at edge N. Entry 0 is compared against `y` at edge N+1.
- `busy` rises one cycle after `start`.
- `done` rises the cycle after the edge that sees `last` (or that compares entry `DEPTH-1`).
- A run of K entries before the marker takes K+1 RUN cycles.
- Stimulus alignment is the bench's responsibility. The stimulus index is driven 1 ns after the rising edge, and the DUT `y` is registered, so expected entry i corresponds to stimulus i−1 plus the FSM latency. The table is built already shifted.

## Configuration
- **`FSM29_FIRST_ERR_EN` defined:** `first_err_idx` and `seen_err` are implemented as above.
- **`FSM29_FIRST_ERR_EN` undefined:**
  - `first_err_idx` is tied to 0 and `seen_err` is removed.
  - `err_count` and `pass` behave identically.

## Structure
- **Package `fsm29_check_pkg`:**
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t`
  - `typedef struct packed {logic last; logic exp_y;} chk_entry_t`
  - Default `CNT_W`.
- **Sub-module `fsm29_vec_mem`:**
  - `DEPTH` × 2-bit register array.
  - Synchronous write, combinational read.
  - No reset.
- **Top module:** FSM, counters and compare logic.

## Test plan
- **All-match run.** Load entries 0–3 with `exp_y` = 1,0,0,1 and entry 4 with `last = 1`. Drive matching `y` and pulse `start`. Required: `done` after 5 RUN cycles, `pass = 1`, `err_count = 0`, `vec_idx = 4`.
- **Two mismatches.** Same table; invert `y` at entries 1 and 3. Required: `err_count = 2`, `first_err_idx = 1`, `pass = 0`. With the macro undefined, `first_err_idx = 0`.
- **Empty table.** Entry 0 has `last = 1`. Required: `busy` for exactly 1 cycle, then `done = 1`, `pass = 1`.
- **Implicit end marker.** `DEPTH = 4`, no `last` bit anywhere, all entries mismatch. Required: `err_count = 4`, DONE after 4 RUN cycles, `vec_idx = 3`.
- **Reset and ignored controls mid-run.**
  - Assert `reset` low at entry 2 of the all-match run. Required: same cycle, `busy = 0`, `err_count = 0`, `vec_idx = 0`, state IDLE.
  - A `load_en` during RUN is ignored; verify it by reading the entry back on a re-run.
  - A `start` during RUN does not reset `vec_idx`.
- **Saturation.** `CNT_W = 2`, 6 mismatching entries. Required: `err_count = 3`, `pass = 0`.

Source files
------------

// File: rtl/fsm29_check_pkg.sv
// Shared types and defaults for the fsm29 response checker.
package fsm29_check_pkg;

    localparam int unsigned DEPTH_DEFAULT = 256;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t;

    typedef struct packed {
        logic last;
        logic exp_y;
    } chk_entry_t;

endpackage

// File: rtl/fsm29_vec_mem.sv
// Expected-response table: synchronous write, combinational read, no reset.
module fsm29_vec_mem
    import fsm29_check_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  chk_entry_t    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output chk_entry_t    rd_data_o
);

    chk_entry_t mem_q [DEPTH];

    // Table write; contents survive reset so a board run can be repeated.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fsm29_resp_checker.sv
// Response checker: compares live y against one table entry per clock after
// start, stopping at a 'last' entry or after entry DEPTH-1.
// Optional feature macro: FSM29_FIRST_ERR_EN (first-mismatch index tracking).
module fsm29_resp_checker
    import fsm29_check_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [1:0]       load_data,
    input  logic             start,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [AW-1:0]    first_err_idx,
    output logic [AW-1:0]    vec_idx
);

    chk_state_t       state_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;
    logic [AW-1:0]    vec_idx_q;
    chk_entry_t       entry;
    logic             mem_we;
    logic             mismatch;
    logic             at_end;

`ifdef FSM29_FIRST_ERR_EN
    logic [AW-1:0]    first_idx_q;
    logic             seen_err_q;
`endif

    // The table is frozen while a run is in progress.
    assign mem_we = load_en && (state_q != RUN);

    fsm29_vec_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (mem_we),
        .wr_addr_i (load_addr),
        .wr_data_i (chk_entry_t'(load_data)),
        .rd_addr_i (vec_idx_q),
        .rd_data_o (entry)
    );

    // Compare of the current entry and saturating next error count.
    always_comb begin
        mismatch  = !entry.last && (y != entry.exp_y);
        at_end    = (vec_idx_q == AW'(DEPTH - 1));
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Run-control FSM with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            vec_idx_q   <= '0;
`ifdef FSM29_FIRST_ERR_EN
            first_idx_q <= '0;
            seen_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_cnt_q   <= '0;
                        vec_idx_q   <= '0;
`ifdef FSM29_FIRST_ERR_EN
                        first_idx_q <= '0;
                        seen_err_q  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    err_cnt_q <= err_cnt_d;
`ifdef FSM29_FIRST_ERR_EN
                    if (mismatch && !seen_err_q) begin
                        first_idx_q <= vec_idx_q;
                        seen_err_q  <= 1'b1;
                    end
`endif
                    // A 'last' entry ends without a compare; entry DEPTH-1
                    // is compared (via err_cnt_d) and then ends the run.
                    if (entry.last || at_end) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end else begin
                        vec_idx_q <= vec_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_cnt_q;
    assign vec_idx   = vec_idx_q;
`ifdef FSM29_FIRST_ERR_EN
    assign first_err_idx = first_idx_q;
`else
    assign first_err_idx = '0;
`endif

endmodule
